lifo_rr_arbiter: RTL and testbench

//  Shares one 8-deep LIFO between N_REQ requesters via round-robin arbitration.
//  It serialises push/pop requests and drives the LIFO push/pop/din pins itself.

---
 rtl/lifo_arb_pkg.sv | 17 +
 rtl/lifo_rr_arbiter_rr_picker.sv | 29 ++
 rtl/lifo_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_lifo_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the LIFO round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lifo_arb_pkg;

    // One granted op walks ARB -> ISSUE -> RESP and back to ARB.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Per-requester op encoding on the op[] inputs.
    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/lifo_rr_arbiter_rr_picker.sv
// Round-robin picker: first asserted req scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid is low when no request is pending.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites the others.
    always_comb begin
        logic [IW-1:0] w_cand;
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(rr_ptr) + k) % N_REQ);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter sharing one LIFO between N_REQ requesters, one op at a time.
// Latency: req seen in ARB cycle T -> LIFO pin op in T+1 -> ack/err/rdata in T+2.
// Backpressure: requesters hold req until ack/err; req is ignored outside ARB.
module lifo_rr_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    op,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    err,
    output logic [DW-1:0]       rdata,
    output logic                rdata_valid,
    output logic                lifo_push,
    output logic                lifo_pop,
    output logic [DW-1:0]       lifo_din,
    input  logic [DW-1:0]       lifo_dout,
    input  logic                lifo_full,
    input  logic                lifo_empty
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_gnt_idx;
    logic              r_gnt_op;
    logic [DW-1:0]     r_gnt_data;

    logic [N_REQ-1:0]  r_ack;
    logic [N_REQ-1:0]  r_err;
    logic [DW-1:0]     r_rdata;
    logic              r_rdata_valid;
    logic              r_lifo_push;
    logic              r_lifo_pop;
    logic [DW-1:0]     r_lifo_din;

    logic              w_pick_vld;
    logic [IW-1:0]     w_pick_idx;
    logic [DW-1:0]     w_wdata_arr [N_REQ];
    logic              w_sel_push;
    logic              w_sel_pop;
    logic              w_issue_ok;
    logic              w_gnt_is_pop;
    logic [N_REQ-1:0]  w_gnt_onehot;

    // Unpack the flat write-data bus into one lane per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_wdata
        assign w_wdata_arr[g] = wdata[g*DW +: DW];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_vld),
        .idx    (w_pick_idx)
    );

    assign w_sel_push   = (op[w_pick_idx] == OP_PUSH);
    assign w_sel_pop    = (op[w_pick_idx] == OP_POP);
    assign w_gnt_is_pop = (r_gnt_op == OP_POP);
    // Outcome is judged on the full/empty flags seen during ISSUE.
    assign w_issue_ok   = w_gnt_is_pop ? !lifo_empty : !lifo_full;
    assign w_gnt_onehot = N_REQ'(1) << r_gnt_idx;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: wait in ARB for a request, then one cycle each of ISSUE and RESP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_pick_vld) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    // Capture the winner's index, op and data when leaving ARB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_idx  <= '0;
            r_gnt_op   <= OP_POP;
            r_gnt_data <= '0;
        end else if (r_state == ARB && w_pick_vld) begin
            r_gnt_idx  <= w_pick_idx;
            r_gnt_op   <= op[w_pick_idx];
            r_gnt_data <= w_wdata_arr[w_pick_idx];
        end
    end

    // Registered LIFO pins, high only for the ISSUE cycle. The LIFO only changes
    // on our own pins, which are low in ARB, so full/empty seen in ARB equal the
    // values present during ISSUE and the refused cases never pulse a pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lifo_push <= 1'b0;
            r_lifo_pop  <= 1'b0;
            r_lifo_din  <= '0;
        end else begin
            r_lifo_push <= 1'b0;
            r_lifo_pop  <= 1'b0;
            r_lifo_din  <= '0;
            if (r_state == ARB && w_pick_vld) begin
                if (w_sel_push && !lifo_full) begin
                    r_lifo_push <= 1'b1;
                    r_lifo_din  <= w_wdata_arr[w_pick_idx];
                end
                if (w_sel_pop && !lifo_empty) begin
                    r_lifo_pop <= 1'b1;
                end
            end
        end
    end

    // Response pulses, pop data capture and round-robin pointer advance at end of ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack         <= '0;
            r_err         <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_ack         <= '0;
            r_err         <= '0;
            r_rdata_valid <= 1'b0;
            if (r_state == ISSUE) begin
                r_ack         <= w_issue_ok ? w_gnt_onehot : '0;
                r_err         <= w_issue_ok ? '0 : w_gnt_onehot;
                r_rdata_valid <= w_issue_ok && w_gnt_is_pop;
                if (w_issue_ok && w_gnt_is_pop) begin
                    r_rdata <= lifo_dout;
                end
                // Pointer moves past the winner even when its op was refused.
                r_rr_ptr <= (r_gnt_idx == IW'(N_REQ - 1)) ? '0 : r_gnt_idx + IW'(1);
            end
        end
    end

    assign ack         = r_ack;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign lifo_push   = r_lifo_push;
    assign lifo_pop    = r_lifo_pop;
    assign lifo_din    = r_lifo_din;

endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// Bench for lifo_rr_arbiter: 8-deep LIFO environment, queue-based reference model,
// directed scenarios with literal expectations, then randomized requesters.
module tb_lifo_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    op    = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [DW-1:0]   rdata;
    logic            rdata_valid;
    logic            lifo_push;
    logic            lifo_pop;
    logic [DW-1:0]   lifo_din;
    logic [DW-1:0]   lifo_dout;
    logic            lifo_full;
    logic            lifo_empty;

    int n_tests = 0;
    int n_fail  = 0;

    lifo_rr_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .op          (op),
        .wdata       (wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .lifo_push   (lifo_push),
        .lifo_pop    (lifo_pop),
        .lifo_din    (lifo_din),
        .lifo_dout   (lifo_dout),
        .lifo_full   (lifo_full),
        .lifo_empty  (lifo_empty)
    );

    always #5 clk = ~clk;

    // ---------------- LIFO environment (shares the reset net) ----------------
    logic [DW-1:0] stk [8];
    int            cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 0;
        end else if (lifo_push && cnt < 8) begin
            stk[cnt] <= lifo_din;
            cnt      <= cnt + 1;
        end else if (lifo_pop && cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign lifo_dout  = (cnt > 0) ? stk[cnt-1] : '0;
    assign lifo_full  = (cnt == 8);
    assign lifo_empty = (cnt == 0);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 waiting for a request, 1 op on the LIFO pins, 2 response pulses.
    int            m_phase = 0;
    int            m_ptr   = 0;
    int            m_idx   = 0;
    bit            m_op    = 1'b0;
    bit            m_ok    = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_stack [$];
    int            m_wait [N];

    always @(negedge clk) begin : model_chk
        logic [N-1:0]  e_ack;
        logic [N-1:0]  e_err;
        logic          e_rv;
        logic          e_push;
        logic          e_pop;
        logic [DW-1:0] e_din;
        int            w;
        e_ack = '0; e_err = '0; e_rv = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_din = '0; w = -1;
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_rdata = '0;
            m_stack.delete();
            for (int j = 0; j < N; j++) m_wait[j] = 0;
        end else begin
            if (m_phase == 1) begin
                e_push = m_op && (m_stack.size() < 8);
                e_pop  = !m_op && (m_stack.size() > 0);
                e_din  = e_push ? m_data : '0;
            end
            if (m_phase == 2) begin
                e_ack = m_ok ? (N'(1) << m_idx) : '0;
                e_err = m_ok ? '0 : (N'(1) << m_idx);
                e_rv  = m_ok && !m_op;
            end
        end
        check("m_ack",   ack,         e_ack);
        check("m_err",   err,         e_err);
        check("m_rv",    rdata_valid, e_rv);
        check("m_rdata", rdata,       m_rdata);
        check("m_push",  lifo_push,   e_push);
        check("m_pop",   lifo_pop,    e_pop);
        check("m_din",   lifo_din,    e_din);
        check("m_count", cnt,         m_stack.size());
        if (!reset) begin
            case (m_phase)
                0: begin
                    for (int j = 0; j < N; j++) if (!req[j]) m_wait[j] = 0;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    if (w >= 0) begin
                        m_idx   = w;
                        m_op    = op[w];
                        m_data  = wdata[w*DW +: DW];
                        m_phase = 1;
                        m_wait[w] = 0;
                        for (int j = 0; j < N; j++) begin
                            if (j != w && req[j]) begin
                                m_wait[j]++;
                                check("fairness", m_wait[j] <= N - 1, 1);
                            end
                        end
                    end
                end
                1: begin
                    m_ok = m_op ? (m_stack.size() < 8) : (m_stack.size() > 0);
                    if (m_ok && m_op) m_stack.push_back(m_data);
                    if (m_ok && !m_op) m_rdata = m_stack.pop_back();
                    m_ptr   = (m_idx + 1) % N;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_any(output logic [N-1:0] a, output logic [N-1:0] e, output bit sp,
                            output bit spop, output logic [DW-1:0] din, output bit rv,
                            output logic [DW-1:0] rd, output int cyc);
        a = '0; e = '0; sp = 1'b0; spop = 1'b0; din = '0; rv = 1'b0; rd = '0; cyc = 99;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #2;
            if (lifo_push) begin sp = 1'b1; din = lifo_din; end
            if (lifo_pop) spop = 1'b1;
            if ((ack | err) != '0) begin
                a = ack; e = err; rv = rdata_valid; rd = rdata; cyc = c;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL resp_timeout: got no ack/err within 12 cycles, required one");
    endtask

    task automatic run_op(input int idx, input bit o, input logic [DW-1:0] d,
                          output logic [N-1:0] a, output logic [N-1:0] e, output bit sp,
                          output bit spop, output logic [DW-1:0] din, output bit rv,
                          output logic [DW-1:0] rd, output int cyc);
        @(posedge clk); #1;
        req[idx] = 1'b1;
        op[idx]  = o;
        wdata[idx*DW +: DW] = d;
        wait_any(a, e, sp, spop, din, rv, rd, cyc);
        req[idx] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [N-1:0]  a, e, dn;
        bit            sp, spop, rv;
        logic [DW-1:0] din, rd;
        int            cyc;
        int            order [5];
        int            exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #2;
        check("rst_ack",   ack,         0);
        check("rst_err",   err,         0);
        check("rst_rv",    rdata_valid, 0);
        check("rst_rdata", rdata,       0);
        check("rst_push",  lifo_push,   0);
        check("rst_pop",   lifo_pop,    0);
        check("rst_din",   lifo_din,    0);

        // Single push: pins in T+1, ack in T+2.
        run_op(0, 1'b1, 8'hA5, a, e, sp, spop, din, rv, rd, cyc);
        check("push_seen",    sp,  1);
        check("push_din",     din, 8'hA5);
        check("push_ack",     a,   4'b0001);
        check("push_err",     e,   4'b0000);
        check("push_latency", cyc, 2);
        check("push_count",   cnt, 1);

        // Push 11 then pop from requester 2.
        run_op(1, 1'b1, 8'h11, a, e, sp, spop, din, rv, rd, cyc);
        check("push11_ack", a, 4'b0010);
        run_op(2, 1'b0, 8'h00, a, e, sp, spop, din, rv, rd, cyc);
        check("pop_ack",   a,  4'b0100);
        check("pop_rv",    rv, 1);
        check("pop_rdata", rd, 8'h11);
        run_op(3, 1'b0, 8'h00, a, e, sp, spop, din, rv, rd, cyc);
        check("pop2_rdata", rd,  8'hA5);
        check("pop2_empty", cnt, 0);

        // Pop on empty LIFO is refused without touching the pins.
        run_op(1, 1'b0, 8'h00, a, e, sp, spop, din, rv, rd, cyc);
        check("epop_err", e,    4'b0010);
        check("epop_ack", a,    4'b0000);
        check("epop_pin", spop, 0);
        check("epop_rv",  rv,   0);

        // Fill to 8, then a ninth push is refused; pop returns the last push.
        for (int k = 1; k <= 8; k++) begin
            run_op(k % N, 1'b1, 8'(k), a, e, sp, spop, din, rv, rd, cyc);
            check($sformatf("fill%0d_ack", k), a, N'(1) << (k % N));
        end
        run_op(1, 1'b1, 8'h09, a, e, sp, spop, din, rv, rd, cyc);
        check("full_err",   e,   4'b0010);
        check("full_pin",   sp,  0);
        check("full_count", cnt, 8);
        run_op(3, 1'b0, 8'h00, a, e, sp, spop, din, rv, rd, cyc);
        check("full_pop_rdata", rd, 8'h08);

        // All four held continuously from a fresh pointer.
        pulse_reset();
        @(posedge clk); #1;
        req = '1;
        op  = '1;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 5; k++) begin
            wait_any(a, e, sp, spop, din, rv, rd, cyc);
            order[k] = -1;
            for (int j = 0; j < N; j++) if ((a | e) == (N'(1) << j)) order[k] = j;
        end
        req = '0;
        for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), order[k], exp_order[k]);

        // Move the pointer to 3, then reset in the middle of the next ISSUE.
        run_op(2, 1'b1, 8'h33, a, e, sp, spop, din, rv, rd, cyc);
        check("pre_rst_ack", a, 4'b0100);
        @(posedge clk); #1;
        req[1] = 1'b1; op[1] = 1'b1; wdata[1*DW +: DW] = 8'h44;
        @(posedge clk); #1;
        check("issue_push", lifo_push, 1);
        check("issue_din",  lifo_din,  8'h44);
        reset = 1'b1;
        #1;
        check("midrst_push", lifo_push, 0);
        check("midrst_din",  lifo_din,  0);
        check("midrst_resp", ack | err, 0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        reset  = 1'b0;
        check("midrst_count", cnt, 0);
        repeat (2) begin
            @(posedge clk); #2;
            check("post_rst_noresp", ack | err, 0);
        end
        @(posedge clk); #1;
        req[0] = 1'b1; op[0] = 1'b1; wdata[0*DW +: DW] = 8'h55;
        req[3] = 1'b1; op[3] = 1'b1; wdata[3*DW +: DW] = 8'h66;
        wait_any(a, e, sp, spop, din, rv, rd, cyc);
        check("post_rst_first", a, 4'b0001);
        req[0] = 1'b0;
        wait_any(a, e, sp, spop, din, rv, rd, cyc);
        check("post_rst_second", a, 4'b1000);
        req[3] = 1'b0;

        // Randomized requesters obeying the hold/drop rule.
        repeat (3000) begin
            @(negedge clk);
            dn = ack | err;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (dn[i] || !req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        op[i]  = 1'($urandom_range(1));
                        wdata[i*DW +: DW] = 8'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end

        // Let outstanding ops complete, then stop.
        for (int c = 0; c < 300 && req != '0; c++) begin
            @(negedge clk);
            dn = ack | err;
            @(posedge clk); #1;
            req = req & ~dn;
        end
        check("drain_done", req, 0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
